// File: rtl/bcast_arbiter.sv
// Purpose: merges four per-unit tag-ready streams into two result-bus broadcast slots per cycle; optional BCAST_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: 2 cycles minimum: a tag enqueued at edge E0 is selected during the next cycle and broadcast after edge E1.
// Backpressure: req_ready[i] drops while requester i holds 2 queued tags (registered count only); blocked cycles are counted in stall_cnt.

`ifndef PHY_REG_SEL
`define PHY_REG_SEL 7
`endif

module bcast_arbiter (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [3:0]              req_valid,
    input  logic [`PHY_REG_SEL-1:0] req_tag_0,
    input  logic [`PHY_REG_SEL-1:0] req_tag_1,
    input  logic [`PHY_REG_SEL-1:0] req_tag_2,
    input  logic [`PHY_REG_SEL-1:0] req_tag_3,
    output logic [3:0]              req_ready,
    output logic                    bc_valid_1,
    output logic                    bc_valid_2,
    output logic [`PHY_REG_SEL-1:0] bc_dst_1,
    output logic [`PHY_REG_SEL-1:0] bc_dst_2,
    output logic [15:0]             stall_cnt
);

    localparam int TW = `PHY_REG_SEL;
    typedef logic [TW-1:0] tag_t;

    // Per-requester 2-entry queues: storage, occupancy and 1-bit wrapping pointers.
    tag_t       mem_q    [4][2];
    logic [1:0] cnt_q    [4];
    logic       rd_ptr_q [4];
    logic       wr_ptr_q [4];

    tag_t       req_tag  [4];
    tag_t       head     [4];
    logic [3:0] nonempty;
    logic [3:0] push;
    logic [3:0] pop;

    // Slot selection results for the current cycle.
    logic       g1_vld;
    logic [1:0] g1_idx;
    logic       g2_vld;
    logic [1:0] g2_idx;
    logic [1:0] scan_start;
    logic [1:0] scan_idx;
    logic [1:0] last_idx;

    // Registered broadcast outputs.
    logic       bc_valid_1_q;
    logic       bc_valid_2_q;
    tag_t       bc_dst_1_q;
    tag_t       bc_dst_2_q;
    logic [15:0] stall_cnt_q;

    assign req_tag[0] = req_tag_0;
    assign req_tag[1] = req_tag_1;
    assign req_tag[2] = req_tag_2;
    assign req_tag[3] = req_tag_3;

    // Queue status, ready and enqueue/dequeue strobes; flush suppresses both.
    always_comb begin
        req_ready = '0;
        nonempty  = '0;
        push      = '0;
        pop       = '0;
        for (int i = 0; i < 4; i++) begin
            head[i]      = mem_q[i][rd_ptr_q[i]];
            req_ready[i] = (cnt_q[i] != 2'd2);
            nonempty[i]  = (cnt_q[i] != 2'd0);
            push[i]      = !flush && req_valid[i] && req_ready[i];
            pop[i]       = !flush && ((g1_vld && (g1_idx == 2'(i))) ||
                                      (g2_vld && (g2_idx == 2'(i))));
        end
    end

`ifdef BCAST_ROUND_ROBIN_EN
    logic [1:0] rr_q;

    // Round-robin pointer moves past the last granted requester; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q <= 2'd0;
        end else if (!flush && g1_vld) begin
            rr_q <= last_idx + 2'd1;
        end
    end

    assign scan_start = rr_q;
`else
    assign scan_start = 2'd0;
`endif

    // Pick the first two non-empty queues in scan order starting at scan_start.
    always_comb begin
        g1_vld   = 1'b0;
        g1_idx   = 2'd0;
        g2_vld   = 1'b0;
        g2_idx   = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = scan_start + 2'(k);
            if (nonempty[scan_idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_idx = scan_idx;
                end
            end
        end
        last_idx = g2_vld ? g2_idx : g1_idx;
    end

    // Tag storage is written on accept and needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= req_tag[i];
            end
        end
    end

    // Occupancy and pointers; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset || flush) begin
                cnt_q[i]    <= 2'd0;
                rd_ptr_q[i] <= 1'b0;
                wr_ptr_q[i] <= 1'b0;
            end else begin
                if (push[i]) begin
                    wr_ptr_q[i] <= ~wr_ptr_q[i];
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= ~rd_ptr_q[i];
                end
                cnt_q[i] <= cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

    // Register the selected heads onto the broadcast slots; unused slots carry tag 0.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            bc_valid_1_q <= 1'b0;
            bc_valid_2_q <= 1'b0;
            bc_dst_1_q   <= '0;
            bc_dst_2_q   <= '0;
        end else begin
            bc_valid_1_q <= g1_vld;
            bc_valid_2_q <= g2_vld;
            bc_dst_1_q   <= g1_vld ? head[g1_idx] : '0;
            bc_dst_2_q   <= g2_vld ? head[g2_idx] : '0;
        end
    end

    // Saturating count of cycles with at least one blocked request; flush does not touch it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else if (((req_valid & ~req_ready) != 4'd0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bc_valid_1 = bc_valid_1_q;
    assign bc_valid_2 = bc_valid_2_q;
    assign bc_dst_1   = bc_dst_1_q;
    assign bc_dst_2   = bc_dst_2_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
